// File: rtl/register_file_sb.sv
// register_file_sb: parametrised register file with write-to-read bypass and a
// per-register pending scoreboard used by the hazard/stall logic. Decode reads
// and reserves destination registers; writeback writes and releases them.
`timescale 1ns/1ps
module register_file_sb #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr_a,
    input  logic [ADDR_BITS-1:0] addr_b,
    output logic [WIDTH-1:0]     data_a,
    output logic [WIDTH-1:0]     data_b,
    input  logic                 write,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 reserve,
    input  logic [ADDR_BITS-1:0] addr_res,
    output logic                 pending_a,
    output logic                 pending_b,
    output logic [ADDR_BITS:0]   pending_count
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WIDTH-1:0]   regs_r [DEPTH];
    logic [DEPTH-1:0]   pending_r;
    logic [ADDR_BITS:0] count_r;

    logic               wr_eff_s;
    logic               res_eff_s;
    logic               set_s;
    logic               clr_s;
    logic [DEPTH-1:0]   pend_next_s;
    logic [ADDR_BITS:0] count_next_s;

    // True when the address is the hard-wired zero register.
    function automatic logic is_zero_addr(input logic [ADDR_BITS-1:0] a);
        return (ZERO_REG != 0) && (a == {ADDR_BITS{1'b0}});
    endfunction

    // Read value for one port: zero register, then same-cycle bypass, then storage.
    function automatic logic [WIDTH-1:0] read_value(
        input logic [ADDR_BITS-1:0] a,
        input logic                 wr_eff,
        input logic [ADDR_BITS-1:0] wa,
        input logic [WIDTH-1:0]     wd,
        input logic [WIDTH-1:0]     stored
    );
        logic [WIDTH-1:0] v;
        if (is_zero_addr(a)) begin
            v = {WIDTH{1'b0}};
        end else if (wr_eff && (wa == a)) begin
            v = wd;
        end else begin
            v = stored;
        end
        return v;
    endfunction

    // Pending for one port: a value being written this cycle is ready via bypass,
    // unless the same address is re-reserved by a new producer this cycle.
    function automatic logic read_pending(
        input logic                 a_pend,
        input logic [ADDR_BITS-1:0] a,
        input logic                 wr_eff,
        input logic [ADDR_BITS-1:0] wa,
        input logic                 res_eff,
        input logic [ADDR_BITS-1:0] ra
    );
        return a_pend && !(wr_eff && (wa == a) && !(res_eff && (ra == a)));
    endfunction

    // Qualify write/reserve requests against the zero register.
    always_comb begin
        wr_eff_s  = write && !is_zero_addr(addr_in);
        res_eff_s = reserve && !is_zero_addr(addr_res);
    end

    // Next scoreboard state: reserve wins over a same-address write.
    always_comb begin
        pend_next_s = pending_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (res_eff_s && (addr_res == ADDR_BITS'(i))) begin
                pend_next_s[i] = 1'b1;
            end else if (wr_eff_s && (addr_in == ADDR_BITS'(i))) begin
                pend_next_s[i] = 1'b0;
            end else begin
                pend_next_s[i] = pending_r[i];
            end
        end
    end

    // Counter delta: at most one bit rises (reserve) and one falls (write) per cycle.
    always_comb begin
        set_s        = res_eff_s && !pending_r[addr_res];
        clr_s        = wr_eff_s && pending_r[addr_in] &&
                       !(res_eff_s && (addr_res == addr_in));
        count_next_s = count_r + {{ADDR_BITS{1'b0}}, set_s}
                               - {{ADDR_BITS{1'b0}}, clr_s};
    end

    // Combinational read ports with bypass and pending flags.
    always_comb begin
        data_a    = read_value(addr_a, wr_eff_s, addr_in, data_in, regs_r[addr_a]);
        data_b    = read_value(addr_b, wr_eff_s, addr_in, data_in, regs_r[addr_b]);
        pending_a = read_pending(pending_r[addr_a], addr_a, wr_eff_s, addr_in,
                                 res_eff_s, addr_res);
        pending_b = read_pending(pending_r[addr_b], addr_b, wr_eff_s, addr_in,
                                 res_eff_s, addr_res);
    end

    // Register storage, scoreboard and pending counter; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {WIDTH{1'b0}};
            end
            pending_r <= {DEPTH{1'b0}};
            count_r   <= {(ADDR_BITS+1){1'b0}};
        end else begin
            if (wr_eff_s) begin
                regs_r[addr_in] <= data_in;
            end
            pending_r <= pend_next_s;
            count_r   <= count_next_s;
        end
    end

    assign pending_count = count_r;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed testbench for register_file_sb: default 32x32 instance with a zero
// register, plus a 16-bit, 8-entry instance without one.
`timescale 1ns/1ps
module tb_register_file_sb;

    logic        clk;
    logic        reset;
    int          total;
    int          bad;

    // Default instance (WIDTH=32, ADDR_BITS=5, ZERO_REG=1)
    logic [4:0]  addr_a, addr_b, addr_in, addr_res;
    logic [31:0] data_a, data_b, data_in;
    logic        write, reserve, pending_a, pending_b;
    logic [5:0]  pending_count;

    // Small instance (WIDTH=16, ADDR_BITS=3, ZERO_REG=0)
    logic [2:0]  s_addr_a, s_addr_b, s_addr_in, s_addr_res;
    logic [15:0] s_data_a, s_data_b, s_data_in;
    logic        s_write, s_reserve, s_pending_a, s_pending_b;
    logic [3:0]  s_pending_count;

    register_file_sb dut (
        .clk(clk), .reset(reset),
        .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
        .write(write), .addr_in(addr_in), .data_in(data_in),
        .reserve(reserve), .addr_res(addr_res),
        .pending_a(pending_a), .pending_b(pending_b),
        .pending_count(pending_count)
    );

    register_file_sb #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(0)) dut_small (
        .clk(clk), .reset(reset),
        .addr_a(s_addr_a), .addr_b(s_addr_b), .data_a(s_data_a), .data_b(s_data_b),
        .write(s_write), .addr_in(s_addr_in), .data_in(s_data_in),
        .reserve(s_reserve), .addr_res(s_addr_res),
        .pending_a(s_pending_a), .pending_b(s_pending_b),
        .pending_count(s_pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; write = 1'b1; addr_in = 5'd7; data_in = 32'hDEADBEEF;
        reserve = 1'b1; addr_res = 5'd7;
        s_write = 1'b1; s_addr_in = 3'd7; s_data_in = 16'h1234;
        s_reserve = 1'b1; s_addr_res = 3'd7;
        tick();
        tick();
        reset = 1'b0; write = 1'b0; reserve = 1'b0; s_write = 1'b0; s_reserve = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            addr_a = 5'(i); addr_b = 5'(31 - i);
            #1;
            total++;
            if (data_a !== 32'h0 || data_b !== 32'h0) begin
                bad++;
                $display("FAIL reset_data addr=%0d got a=%h b=%h exp=0", i, data_a, data_b);
            end
            total++;
            if (pending_a !== 1'b0 || pending_b !== 1'b0) begin
                bad++;
                $display("FAIL reset_pending addr=%0d got a=%b b=%b exp=0", i, pending_a, pending_b);
            end
        end
        total++;
        if (pending_count !== 6'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=0", pending_count);
        end
        addr_a = 5'd7; s_addr_a = 3'd7;
        #1;
        total++;
        if (data_a !== 32'h0 || s_data_a !== 16'h0) begin
            bad++;
            $display("FAIL reset_over_write got=%h/%h exp=0", data_a, s_data_a);
        end
        total++;
        if (s_pending_count !== 4'd0) begin
            bad++;
            $display("FAIL reset_small_count got=%0d exp=0", s_pending_count);
        end
    endtask

    task automatic test_bypass();
        tick();
        write = 1'b1; addr_in = 5'd3; data_in = 32'h12345678; addr_a = 5'd3;
        #1;
        total++;
        if (data_a !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass_same_cycle got=%h exp=12345678", data_a);
        end
        tick();
        write = 1'b0;
        #1;
        total++;
        if (data_a !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass_stored got=%h exp=12345678", data_a);
        end
        write = 1'b1; addr_in = 5'd0; data_in = 32'hFFFFFFFF; addr_a = 5'd0;
        #1;
        total++;
        if (data_a !== 32'h0 || pending_a !== 1'b0) begin
            bad++;
            $display("FAIL zero_bypass got=%h pend=%b exp=0", data_a, pending_a);
        end
        tick();
        write = 1'b0;
        #1;
        total++;
        if (data_a !== 32'h0) begin
            bad++;
            $display("FAIL zero_stored got=%h exp=0", data_a);
        end
    endtask

    task automatic test_reserve_release();
        reserve = 1'b1; addr_res = 5'd5;
        tick();
        reserve = 1'b0; addr_a = 5'd5;
        #1;
        total++;
        if (pending_a !== 1'b1 || pending_count !== 6'd1) begin
            bad++;
            $display("FAIL reserve_r5 got pend=%b cnt=%0d exp pend=1 cnt=1", pending_a, pending_count);
        end
        write = 1'b1; addr_in = 5'd5; data_in = 32'h000000A5;
        #1;
        total++;
        if (pending_a !== 1'b0 || data_a !== 32'h000000A5) begin
            bad++;
            $display("FAIL release_bypass got pend=%b data=%h exp pend=0 data=a5", pending_a, data_a);
        end
        tick();
        write = 1'b0;
        #1;
        total++;
        if (pending_count !== 6'd0 || pending_a !== 1'b0) begin
            bad++;
            $display("FAIL release_count got cnt=%0d pend=%b exp cnt=0 pend=0", pending_count, pending_a);
        end
        // write to a non-pending register leaves the count alone
        write = 1'b1; addr_in = 5'd6; data_in = 32'h66;
        tick();
        write = 1'b0;
        #1;
        total++;
        if (pending_count !== 6'd0) begin
            bad++;
            $display("FAIL write_nonpending got cnt=%0d exp=0", pending_count);
        end
    endtask

    task automatic test_same_addr();
        reserve = 1'b1; addr_res = 5'd9;
        tick();
        write = 1'b1; addr_in = 5'd9; data_in = 32'h77; addr_a = 5'd9;
        #1;
        total++;
        if (pending_a !== 1'b1 || data_a !== 32'h77) begin
            bad++;
            $display("FAIL same_addr_comb got pend=%b data=%h exp pend=1 data=77", pending_a, data_a);
        end
        tick();
        write = 1'b0; reserve = 1'b0;
        #1;
        total++;
        if (pending_a !== 1'b1 || pending_count !== 6'd1 || data_a !== 32'h77) begin
            bad++;
            $display("FAIL same_addr_next got pend=%b cnt=%0d data=%h exp 1/1/77", pending_a, pending_count, data_a);
        end
        // same-address reserve+write on a clear register still sets the bit
        reserve = 1'b1; addr_res = 5'd10; write = 1'b1; addr_in = 5'd10; data_in = 32'h10;
        tick();
        reserve = 1'b0; write = 1'b1; addr_in = 5'd9; data_in = 32'h99;
        tick();
        write = 1'b1; addr_in = 5'd10; data_in = 32'h1010;
        #1;
        total++;
        if (pending_count !== 6'd1) begin
            bad++;
            $display("FAIL same_addr_clear got cnt=%0d exp=1", pending_count);
        end
        tick();
        write = 1'b0;
        #1;
        total++;
        if (pending_count !== 6'd0) begin
            bad++;
            $display("FAIL same_addr_drain got cnt=%0d exp=0", pending_count);
        end
    endtask

    task automatic test_diff_addr();
        reserve = 1'b1; addr_res = 5'd4;
        tick();
        reserve = 1'b1; addr_res = 5'd2; write = 1'b1; addr_in = 5'd4; data_in = 32'h44;
        tick();
        reserve = 1'b0; write = 1'b0; addr_a = 5'd2; addr_b = 5'd4;
        #1;
        total++;
        if (pending_count !== 6'd1 || pending_a !== 1'b1 || pending_b !== 1'b0) begin
            bad++;
            $display("FAIL diff_addr got cnt=%0d p2=%b p4=%b exp 1/1/0", pending_count, pending_a, pending_b);
        end
        total++;
        if (data_b !== 32'h44) begin
            bad++;
            $display("FAIL diff_addr_data got=%h exp=44", data_b);
        end
    endtask

    task automatic test_fill();
        for (int r = 1; r < 32; r++) begin
            reserve = 1'b1; addr_res = 5'(r);
            tick();
        end
        reserve = 1'b0;
        #1;
        total++;
        if (pending_count !== 6'd31) begin
            bad++;
            $display("FAIL fill_count got=%0d exp=31", pending_count);
        end
        reserve = 1'b1; addr_res = 5'd0;
        tick();
        addr_res = 5'd17;
        tick();
        reserve = 1'b0; addr_a = 5'd0; addr_b = 5'd31;
        #1;
        total++;
        if (pending_count !== 6'd31 || pending_a !== 1'b0 || pending_b !== 1'b1) begin
            bad++;
            $display("FAIL fill_saturate got cnt=%0d p0=%b p31=%b exp 31/0/1", pending_count, pending_a, pending_b);
        end
    endtask

    task automatic test_small();
        s_write = 1'b1; s_addr_in = 3'd0; s_data_in = 16'hBEEF; s_addr_a = 3'd0;
        #1;
        total++;
        if (s_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL small_r0_bypass got=%h exp=beef", s_data_a);
        end
        tick();
        s_write = 1'b0;
        #1;
        total++;
        if (s_data_a !== 16'hBEEF) begin
            bad++;
            $display("FAIL small_r0_stored got=%h exp=beef", s_data_a);
        end
        for (int r = 0; r < 8; r++) begin
            s_reserve = 1'b1; s_addr_res = 3'(r);
            tick();
        end
        s_addr_res = 3'd0;
        tick();
        s_reserve = 1'b0; s_addr_a = 3'd0;
        #1;
        total++;
        if (s_pending_count !== 4'd8 || s_pending_a !== 1'b1) begin
            bad++;
            $display("FAIL small_fill got cnt=%0d p0=%b exp 8/1", s_pending_count, s_pending_a);
        end
        s_write = 1'b1; s_addr_in = 3'd3; s_data_in = 16'h0333;
        tick();
        s_write = 1'b0; s_addr_b = 3'd3;
        #1;
        total++;
        if (s_pending_count !== 4'd7 || s_pending_b !== 1'b0 || s_data_b !== 16'h0333) begin
            bad++;
            $display("FAIL small_release got cnt=%0d p3=%b d=%h exp 7/0/0333", s_pending_count, s_pending_b, s_data_b);
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0;
        addr_a = 5'd0; addr_b = 5'd0; addr_in = 5'd0; addr_res = 5'd0;
        data_in = 32'h0; write = 1'b0; reserve = 1'b0;
        s_addr_a = 3'd0; s_addr_b = 3'd0; s_addr_in = 3'd0; s_addr_res = 3'd0;
        s_data_in = 16'h0; s_write = 1'b0; s_reserve = 1'b0;
        test_reset();
        test_bypass();
        test_reserve_release();
        test_same_addr();
        test_diff_addr();
        test_fill();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
